// File: rtl/mult_pkg.sv
// Shared definitions for the pipelined 32x32->64 unsigned multiplier.
//   MUL_W / PROD_W : operand and product widths
//   MUL_LATENCY    : edges from operand capture to product on out
//   csa_t / csa()  : 3:2 carry-save compressor on 64-bit rows
//   gp_t           : generate/propagate pair for the prefix adder
package mult_pkg;

  localparam int MUL_W       = 32;
  localparam int PROD_W      = 64;
  localparam int MUL_LATENCY = 4;

  typedef struct packed {
    logic [PROD_W-1:0] s;
    logic [PROD_W-1:0] c;
  } csa_t;

  typedef struct packed {
    logic [PROD_W-1:0] g;
    logic [PROD_W-1:0] p;
  } gp_t;

  // Carry is pre-shifted into its column weight; bit 63 of the raw carry
  // falls off, which is harmless because all arithmetic is mod 2^64.
  function automatic csa_t csa(input logic [PROD_W-1:0] x,
                               input logic [PROD_W-1:0] y,
                               input logic [PROD_W-1:0] z);
    csa_t r;
    r.s = x ^ y ^ z;
    r.c = ((x & y) | (x & z) | (y & z)) << 1;
    return r;
  endfunction

endpackage

// File: rtl/prefix_adder64.sv
// 64-bit Kogge-Stone parallel-prefix adder, carry-in 0, carry-out dropped.
// Ports:
//   x, y : addends
//   s    : x + y mod 2^64
module prefix_adder64
  import mult_pkg::*;
(
  input  logic [63:0] x,
  input  logic [63:0] y,
  output logic [63:0] s
);

  // One prefix level: combine each bit with the bit d positions below it.
  // Bits below d already hold their final group values and pass through.
  function automatic gp_t ks_level(input gp_t in, input int d);
    gp_t r;
    r = in;
    for (int i = d; i < PROD_W; i++) begin
      r.g[i] = in.g[i] | (in.p[i] & in.g[i-d]);
      r.p[i] = in.p[i] & in.p[i-d];
    end
    return r;
  endfunction

  gp_t lv0, lv1, lv2, lv3, lv4, lv5, lv6;

  assign lv0.g = x & y;
  assign lv0.p = x ^ y;

  assign lv1 = ks_level(lv0, 1);
  assign lv2 = ks_level(lv1, 2);
  assign lv3 = ks_level(lv2, 4);
  assign lv4 = ks_level(lv3, 8);
  assign lv5 = ks_level(lv4, 16);
  assign lv6 = ks_level(lv5, 32);

  // lv6.g[i] is the carry out of bit i; bit i+1 consumes it.
  assign s = lv0.p ^ {lv6.g[62:0], 1'b0};

  // Carry-out and final group-propagate are structurally present but unused.
  logic unused_prefix;
  assign unused_prefix = ^{lv6.g[63], lv6.p};

endmodule

// File: rtl/multiplier.sv
// Four-stage free-running unsigned 32x32->64 multiplier.
//   stage 1: operand registers
//   stage 2: AND-array partial products, CSA reduce 32 -> 7 rows
//   stage 3: CSA reduce 7 -> 2 rows (sum, carry)
//   stage 4: Kogge-Stone add, product register
// Ports:
//   a, b  : unsigned operands, captured every rising edge
//   out   : registered 64-bit product, valid 4 edges after capture
//   clock : rising-edge clock
//   reset : asynchronous active-high, clears all pipeline registers
module multiplier
  import mult_pkg::*;
(
  input  logic [MUL_W-1:0]  a,
  input  logic [MUL_W-1:0]  b,
  output logic [PROD_W-1:0] out,
  input  logic              clock,
  input  logic              reset
);

  logic [MUL_W-1:0]  a_q, b_q;
  logic [PROD_W-1:0] rows_d [7];
  logic [PROD_W-1:0] rows_q [7];
  logic [PROD_W-1:0] sum_d, carry_d, sum_q, carry_q;
  logic [PROD_W-1:0] out_d, out_q;

  // Stage 2: four CSA layers, 32 -> 22 -> 15 -> 10 -> 7 rows.
  logic [PROD_W-1:0] l0 [32];
  logic [PROD_W-1:0] l1 [22];
  logic [PROD_W-1:0] l2 [15];
  logic [PROD_W-1:0] l3 [10];
  csa_t              r2;

  always_comb begin
    r2 = '0;
    for (int i = 0; i < MUL_W; i++) begin
      l0[i] = {32'b0, a_q & {MUL_W{b_q[i]}}} << i;
    end
    for (int k = 0; k < 10; k++) begin
      r2 = csa(l0[3*k], l0[3*k+1], l0[3*k+2]);
      l1[2*k]   = r2.s;
      l1[2*k+1] = r2.c;
    end
    l1[20] = l0[30];
    l1[21] = l0[31];
    for (int k = 0; k < 7; k++) begin
      r2 = csa(l1[3*k], l1[3*k+1], l1[3*k+2]);
      l2[2*k]   = r2.s;
      l2[2*k+1] = r2.c;
    end
    l2[14] = l1[21];
    for (int k = 0; k < 5; k++) begin
      r2 = csa(l2[3*k], l2[3*k+1], l2[3*k+2]);
      l3[2*k]   = r2.s;
      l3[2*k+1] = r2.c;
    end
    for (int k = 0; k < 3; k++) begin
      r2 = csa(l3[3*k], l3[3*k+1], l3[3*k+2]);
      rows_d[2*k]   = r2.s;
      rows_d[2*k+1] = r2.c;
    end
    rows_d[6] = l3[9];
  end

  // Stage 3: four CSA layers, 7 -> 5 -> 4 -> 3 -> 2 rows.
  logic [PROD_W-1:0] n1 [5];
  logic [PROD_W-1:0] n2 [4];
  logic [PROD_W-1:0] n3 [3];
  csa_t              r3;

  always_comb begin
    r3 = csa(rows_q[0], rows_q[1], rows_q[2]);
    n1[0] = r3.s;
    n1[1] = r3.c;
    r3 = csa(rows_q[3], rows_q[4], rows_q[5]);
    n1[2] = r3.s;
    n1[3] = r3.c;
    n1[4] = rows_q[6];

    r3 = csa(n1[0], n1[1], n1[2]);
    n2[0] = r3.s;
    n2[1] = r3.c;
    n2[2] = n1[3];
    n2[3] = n1[4];

    r3 = csa(n2[0], n2[1], n2[2]);
    n3[0] = r3.s;
    n3[1] = r3.c;
    n3[2] = n2[3];

    r3 = csa(n3[0], n3[1], n3[2]);
    sum_d   = r3.s;
    carry_d = r3.c;
  end

  // Stage 4: final carry-propagate add.
  prefix_adder64 u_adder (
    .x(sum_q),
    .y(carry_q),
    .s(out_d)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      rows_q  <= '{default: '0};
      sum_q   <= '0;
      carry_q <= '0;
      out_q   <= '0;
    end else begin
      a_q     <= a;
      b_q     <= b;
      rows_q  <= rows_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      out_q   <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_multiplier.sv
module tb_multiplier;
  import mult_pkg::*;

  logic        clock;
  logic        reset;
  logic [31:0] a, b;
  logic [63:0] out;

  multiplier dut (
    .a(a),
    .b(b),
    .out(out),
    .clock(clock),
    .reset(reset)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: every edge with reset low captures one operand pair; the
  // product of the k-th capture since reset must be on out after capture
  // k + MUL_LATENCY - 1. Anything earlier is the flushed value 0.
  logic [63:0] hist [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic [31:0] av, input logic [31:0] bv, input string tag);
    logic [63:0] expv;
    a = av;
    b = bv;
    @(posedge clock);
    if (!reset) hist.push_back(64'(av) * 64'(bv));
    #1;
    expv = '0;
    if (!reset && hist.size() >= MUL_LATENCY) expv = hist[hist.size() - MUL_LATENCY];
    chk(tag, out, expv);
  endtask

  logic [31:0] dir_b [8] = '{32'd20, 32'd30, 32'd40, 32'd50, 32'd60, 32'd70, 32'd80, 32'd10};
  logic [31:0] cor_a [4] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000};
  logic [31:0] cor_b [4] = '{32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h2};
  logic [63:0] cor_p [4] = '{64'h0, 64'hDEAD_BEEF, 64'hFFFF_FFFE_0000_0001, 64'h1_0000_0000};

  initial begin
    reset = 1'b1;
    a = '0;
    b = '0;
    @(posedge clock);
    #1;
    chk("reset_state", out, 64'h0);

    // Release, then a = b = 11111: zero for three edges, product on the fourth.
    reset = 1'b0;
    hist.delete();
    for (int i = 0; i < 6; i++) step(32'd11111, 32'd11111, "rst_release");
    chk("rst_release_value", out, 64'd123454321);

    // Assert reset mid-cycle: out must clear with no clock edge.
    #2;
    reset = 1'b1;
    hist.delete();
    #1;
    chk("async_clear", out, 64'h0);
    for (int i = 0; i < 2; i++) step(32'd11111, 32'd11111, "reset_held");
    reset = 1'b0;

    // Directed products, each held for six cycles.
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 6; i++) step(32'd10, dir_b[k], "directed");
      chk("directed_value", out, 64'(dir_b[k]) * 64'd10);
    end

    // Corner operands.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) step(cor_a[k], cor_b[k], "corner");
      chk("corner_value", out, cor_p[k]);
    end

    // Streaming: a fresh random pair every cycle.
    for (int i = 0; i < 1000; i++) step($urandom, $urandom, "stream");

    // Reset pulse with three products in flight.
    for (int i = 0; i < 3; i++) step($urandom, $urandom, "pre_reset_stream");
    #2;
    reset = 1'b1;
    hist.delete();
    #1;
    chk("midstream_clear", out, 64'h0);
    for (int i = 0; i < 2; i++) step($urandom, $urandom, "midstream_held");
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step($urandom, $urandom, "post_reset_stream");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
